uart_rx_fifo: RTL and testbench

//  Downstream of the UART receiver: detects each byte-complete indication, captures the

---
 rtl/uart_rx_fifo_if.sv | 27 ++
 rtl/uart_rx_fifo.sv | 64 ++++++
 tb/tb_uart_rx_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bus between the UART receiver/CPU side and the receive FIFO.
// The master modport drives the receiver strobe and the CPU controls. The slave modport is the FIFO.
interface uart_rx_fifo_if #(
  parameter int ADDR_W = 3
);
  logic              rx_done;
  logic [7:0]        rx_data;
  logic              rd_en;
  logic              clr_ovr;
  logic              irq_en;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic              irq;

  modport master (
    output rx_done, rx_data, rd_en, clr_ovr, irq_en,
    input  rd_data, empty, full, count, overrun, irq
  );

  modport slave (
    input  rx_done, rx_data, rd_en, clr_ovr, irq_en,
    output rd_data, empty, full, count, overrun, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO that turns each UART byte-complete level into exactly one push.
// It presents the head byte, FIFO status, a sticky overrun flag and a level interrupt to the CPU bus.
module uart_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic            sysclk,
  input  logic            reset,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(DEPTH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              s1, s2, s3;
  logic              overrun_q;

  logic push, pop, wr_ok, fifo_empty, fifo_full;

  // s1/s2 resynchronise rx_done, and s3 is only for edge detection.
  assign push       = s2 & ~s3;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);
  assign pop        = bus.rd_en & ~fifo_empty;
  // A pop on a full FIFO frees the slot the coincident push needs.
  assign wr_ok      = push & (~fifo_full | bus.rd_en);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      s1        <= 1'b0;
      s2        <= 1'b0;
      s3        <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      s1 <= bus.rx_done;
      s2 <= s1;
      s3 <= s2;
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (wr_ok && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !wr_ok) count_q <= count_q - 1'b1;
      if (push && fifo_full && !bus.rd_en) overrun_q <= 1'b1;
      else if (bus.clr_ovr)                overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge sysclk) begin
    if (wr_ok) mem[wr_ptr] <= bus.rx_data;
  end

  assign bus.rd_data = fifo_empty ? 8'h00 : mem[rd_ptr];
  assign bus.empty   = fifo_empty;
  assign bus.full    = fifo_full;
  assign bus.count   = count_q;
  assign bus.overrun = overrun_q;
  assign bus.irq     = bus.irq_en & ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed testbench for uart_rx_fifo, with expected values worked out by hand.
// Inputs are driven and outputs are sampled 1 time unit after the rising clock edge.
module tb_uart_rx_fifo;
  logic sysclk = 1'b0;
  logic reset  = 1'b0;
  int   checks = 0;
  int   errors = 0;

  uart_rx_fifo_if #(.ADDR_W(3)) bus ();

  uart_rx_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus.slave)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  // The byte is written at the third edge after rx_done rises.
  task automatic push_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    checks++;
    if (bus.rd_data !== exp) begin
      errors++;
      $display("FAIL %s rd_data got %h exp %h", name, bus.rd_data, exp);
    end
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    bus.rx_done = 0; bus.rx_data = 0; bus.rd_en = 0; bus.clr_ovr = 0; bus.irq_en = 0;
    reset = 1'b0;
    tick(); tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full got %b exp 0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", bus.count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", bus.overrun); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL rst_rd_data got %h exp 00", bus.rd_data); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_latency();
    bus.rx_data = 8'hA5;
    bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL lat_edge1 empty got %b exp 1", bus.empty); end
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL lat_edge2 empty got %b exp 1", bus.empty); end
    tick();
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL lat_edge3 empty got %b exp 0", bus.empty); end
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL lat_count got %0d exp 1", bus.count); end
    pop_check("lat_pop", 8'hA5);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL lat_empty_after got %b exp 1", bus.empty); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL lat_count_after got %0d exp 0", bus.count); end
  endtask

  task automatic test_hold();
    bus.rx_data = 8'h3C;
    bus.rx_done = 1'b1;
    repeat (100) tick();
    bus.rx_done = 1'b0;
    repeat (4) tick();
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL hold_count got %0d exp 1", bus.count); end
    pop_check("hold_pop", 8'h3C);
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL hold_count_after got %0d exp 0", bus.count); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b exp 1", bus.full); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count got %0d exp 8", bus.count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovf_pre_ovr got %b exp 0", bus.overrun); end
    push_byte(8'h09);
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovf_ovr got %b exp 1", bus.overrun); end
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL ovf_count9 got %0d exp 8", bus.count); end
    for (int i = 1; i <= 8; i++) pop_check("ovf_order", 8'(i));
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL ovf_empty got %b exp 1", bus.empty); end
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", bus.overrun); end
    bus.clr_ovr = 1'b1; tick(); bus.clr_ovr = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b exp 0", bus.overrun); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    bus.rx_data = 8'hEE;
    bus.rx_done = 1'b1; tick();
    bus.rx_done = 1'b0; tick();
    bus.rd_en = 1'b1; tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL fpp_count got %0d exp 8", bus.count); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL fpp_ovr got %b exp 0", bus.overrun); end
    checks++; if (bus.rd_data !== 8'h02) begin errors++; $display("FAIL fpp_head got %h exp 02", bus.rd_data); end
    // An overflow that coincides with clr_ovr must leave the flag set.
    bus.rx_data = 8'h77;
    bus.rx_done = 1'b1; tick();
    bus.rx_done = 1'b0; tick();
    bus.clr_ovr = 1'b1; tick();
    bus.clr_ovr = 1'b0;
    checks++; if (bus.overrun !== 1'b1) begin errors++; $display("FAIL fpp_set_wins got %b exp 1", bus.overrun); end
    bus.clr_ovr = 1'b1; tick(); bus.clr_ovr = 1'b0;
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL fpp_clr got %b exp 0", bus.overrun); end
    for (int i = 2; i <= 8; i++) pop_check("fpp_order", 8'(i));
    pop_check("fpp_ee", 8'hEE);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL fpp_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      push_byte(8'(8'h10 + i));
      if (i >= 2) begin
        checks++; if (bus.count !== 4'd3) begin errors++; $display("FAIL wrap_count got %0d exp 3", bus.count); end
        pop_check("wrap_order", 8'(8'h10 + i - 2));
      end
    end
    pop_check("wrap_tail0", 8'h22);
    pop_check("wrap_tail1", 8'h23);
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", bus.empty); end
  endtask

  task automatic test_irq_reset();
    bus.irq_en = 1'b1;
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL irq_idle got %b exp 0", bus.irq); end
    push_byte(8'h5A);
    checks++; if (bus.irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", bus.irq); end
    push_byte(8'h6B);
    // Assert reset between clock edges so only the asynchronous path can clear the outputs.
    #2 reset = 1'b0;
    #1;
    checks++; if (bus.irq !== 1'b0) begin errors++; $display("FAIL arst_irq got %b exp 0", bus.irq); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL arst_empty got %b exp 1", bus.empty); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL arst_count got %0d exp 0", bus.count); end
    checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL arst_rd_data got %h exp 00", bus.rd_data); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL arst_full got %b exp 0", bus.full); end
    tick();
    reset = 1'b1;
    tick();
    bus.rd_en = 1'b1; tick(); bus.rd_en = 1'b0;
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rd_empty_count got %0d exp 0", bus.count); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rd_empty_empty got %b exp 1", bus.empty); end
    checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL rd_empty_ovr got %b exp 0", bus.overrun); end
    push_byte(8'hC3);
    pop_check("post_reset_pop", 8'hC3);
  endtask

  initial begin
    test_reset();
    test_latency();
    test_hold();
    test_overflow();
    test_full_push_pop();
    test_wrap();
    test_irq_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
